multi_timer: RTL and testbench

- Parametrised multi-channel memory-mapped timer. Successor to the single-channel compare timer.
- NUM_CH independent channels share one global prescaler. Each channel has its own compare, counter, control and status registers, with periodic or one-shot mode and a per-channel interrupt enable.
- Sits on the peripheral bus behind the address decoder, using the same CS_N/RD_N/WR_N strobe interface. Drives one combined active-low interrupt line to the CPU.

---
 rtl/multi_timer_pkg.sv | 18 +
 rtl/multi_timer_channel.sv | 66 ++++++
 rtl/multi_timer.sv | 107 ++++++++++
 tb/tb_multi_timer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared register map and control-bit positions for the multi-channel timer.
// Imported by the top level and by every timer channel.
package multi_timer_pkg;

    localparam logic [7:0] OFF_COMPARE  = 8'h00;
    localparam logic [7:0] OFF_COUNTER  = 8'h04;
    localparam logic [7:0] OFF_CTRL     = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;
    localparam logic [7:0] OFF_PRESCALE = 8'h00;
    localparam logic [7:0] OFF_IRQSUM   = 8'h04;
    localparam logic [3:0] GLOBAL_SEL   = 4'hF;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_W       = 3;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: compare/counter/ctrl/status registers driven by the shared tick.
// A match sets the sticky status flag; the set beats a same-cycle W1C.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              we_compare,
    input  logic              we_ctrl,
    input  logic              we_status,
    input  logic [31:0]       wdata,
    output logic [WIDTH-1:0]  compare,
    output logic [WIDTH-1:0]  counter,
    output logic [CTRL_W-1:0] ctrl,
    output logic              status,
    output logic              irq
);

    logic [WIDTH-1:0]  compare_r;
    logic [WIDTH-1:0]  counter_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic              status_r;
    logic              match_s;

    // Match evaluated on the pre-edge state, so a same-cycle CTRL write still sees the old EN.
    assign match_s = tick & ctrl_r[CTRL_EN] & (counter_r == compare_r);

    // Channel register update
    always_ff @(posedge clk) begin
        if (!reset) begin
            compare_r <= '1;
            counter_r <= '0;
            ctrl_r    <= '0;
            status_r  <= 1'b0;
        end else begin
            if (we_compare) begin
                compare_r <= wdata[WIDTH-1:0];
                counter_r <= '0;
            end else if (tick & ctrl_r[CTRL_EN]) begin
                counter_r <= match_s ? '0 : counter_r + WIDTH'(1);
            end

            if (we_ctrl) begin
                ctrl_r <= wdata[CTRL_W-1:0];
            end else if (match_s & ctrl_r[CTRL_ONESHOT]) begin
                ctrl_r[CTRL_EN] <= 1'b0;
            end

            if (match_s) begin
                status_r <= 1'b1;
            end else if (we_status & wdata[0]) begin
                status_r <= 1'b0;
            end
        end
    end

    assign compare = compare_r;
    assign counter = counter_r;
    assign ctrl    = ctrl_r;
    assign status  = status_r;
    assign irq     = status_r & ctrl_r[CTRL_IE];

endmodule

// File: rtl/multi_timer.sv
// Multi-channel memory-mapped timer: shared prescaler, address decode and read mux
// in front of NUM_CH independent timer channels.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS_N,
    input  logic              RD_N,
    input  logic              WR_N,
    input  logic [11:0]       Addr,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic [NUM_CH-1:0] IrqVec,
    output logic              Intr
);

    logic                         wr_s;
    logic                         rd_s;
    logic [3:0]                   ch_sel_s;
    logic [7:0]                   off_s;
    logic                         tick_s;
    logic [PRE_W-1:0]             prescale_r;
    logic [PRE_W-1:0]             pcnt_r;
    logic [NUM_CH-1:0][31:0]      chan_rd_s;
    logic [31:0]                  chan_data_s;
    logic [31:0]                  data_out_s;

    assign wr_s     = ~CS_N & ~WR_N;
    assign rd_s     = ~CS_N & ~RD_N;
    assign ch_sel_s = Addr[11:8];
    assign off_s    = Addr[7:0];
    assign tick_s   = (pcnt_r == prescale_r);

    // Global prescaler; a PRESCALE write restarts the count
    always_ff @(posedge clk) begin
        if (!reset) begin
            prescale_r <= '0;
            pcnt_r     <= '0;
        end else if (wr_s && (ch_sel_s == GLOBAL_SEL) && (off_s == OFF_PRESCALE)) begin
            prescale_r <= DataIn[PRE_W-1:0];
            pcnt_r     <= '0;
        end else begin
            pcnt_r     <= tick_s ? '0 : pcnt_r + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              sel_s;
        logic [WIDTH-1:0]  cmp_s;
        logic [WIDTH-1:0]  cnt_s;
        logic [CTRL_W-1:0] ctrl_s;
        logic              st_s;

        // NUM_CH never reaches 15, so a channel hit can never alias the global page.
        assign sel_s = (ch_sel_s == 4'(i));

        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick_s),
            .we_compare (wr_s & sel_s & (off_s == OFF_COMPARE)),
            .we_ctrl    (wr_s & sel_s & (off_s == OFF_CTRL)),
            .we_status  (wr_s & sel_s & (off_s == OFF_STATUS)),
            .wdata      (DataIn),
            .compare    (cmp_s),
            .counter    (cnt_s),
            .ctrl       (ctrl_s),
            .status     (st_s),
            .irq        (IrqVec[i])
        );

        assign chan_rd_s[i] = !sel_s                  ? 32'd0 :
                              (off_s == OFF_COMPARE)  ? 32'(cmp_s) :
                              (off_s == OFF_COUNTER)  ? 32'(cnt_s) :
                              (off_s == OFF_CTRL)     ? 32'(ctrl_s) :
                              (off_s == OFF_STATUS)   ? 32'(st_s) : 32'd0;
    end

    // Read mux: at most one channel contributes, everything else reads zero
    always_comb begin
        chan_data_s = 32'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            chan_data_s = chan_data_s | chan_rd_s[k];
        end
        data_out_s = 32'd0;
        if (!rd_s) begin
            data_out_s = 32'd0;
        end else if (ch_sel_s == GLOBAL_SEL) begin
            case (off_s)
                OFF_PRESCALE: data_out_s = 32'(prescale_r);
                OFF_IRQSUM:   data_out_s = 32'(IrqVec);
                default:      data_out_s = 32'd0;
            endcase
        end else begin
            data_out_s = chan_data_s;
        end
    end

    assign DataOut = data_out_s;
    assign Intr    = ~|IrqVec;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: the driver pushes expectations from a register-level
// reference model; a monitor pops and compares on every read and every cycle's IRQ lines.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        CS_N, RD_N, WR_N;
    logic [11:0] Addr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic [3:0]  IrqVec;
    logic        Intr;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q[$];
    logic [3:0]  irq_q[$];

    // Reference model state
    int unsigned m_cmp[4];
    int unsigned m_cnt[4];
    bit          m_en[4], m_os[4], m_ie[4], m_st[4];
    int unsigned m_pre, m_pcnt;

    multi_timer #(.NUM_CH(4), .WIDTH(32), .PRE_W(8)) dut (
        .clk(clk), .reset(reset), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
        .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .IrqVec(IrqVec), .Intr(Intr)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cmp[i] = 32'hFFFF_FFFF; m_cnt[i] = 0;
            m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_st[i] = 0;
        end
        m_pre = 0; m_pcnt = 0;
    endfunction

    function automatic logic [3:0] model_irq();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_st[i] & m_ie[i];
        return v;
    endfunction

    function automatic logic [31:0] model_read(logic [11:0] a);
        int c = int'(a[11:8]);
        int o = int'(a[7:0]);
        if (c == 15) begin
            if (o == 0) return m_pre;
            if (o == 4) return {28'd0, model_irq()};
            return 32'd0;
        end
        if (c >= 4) return 32'd0;
        case (o)
            0:  return m_cmp[c];
            4:  return m_cnt[c];
            8:  return {29'd0, m_ie[c], m_os[c], m_en[c]};
            12: return {31'd0, m_st[c]};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model across one clock edge with the given bus activity.
    function automatic void model_step(bit rst_b, bit w, logic [11:0] a, logic [31:0] d);
        bit tick;
        int c = int'(a[11:8]);
        int o = int'(a[7:0]);
        if (!rst_b) begin
            model_reset();
            return;
        end
        tick = (m_pcnt == m_pre);
        for (int i = 0; i < 4; i++) begin
            bit hit = w && (c == i);
            bit match = tick && m_en[i] && (m_cnt[i] == m_cmp[i]);
            if (hit && o == 0) begin
                m_cmp[i] = d; m_cnt[i] = 0;
            end else if (tick && m_en[i]) begin
                m_cnt[i] = match ? 0 : m_cnt[i] + 1;
            end
            if (match) m_st[i] = 1;
            else if (hit && o == 12 && d[0]) m_st[i] = 0;
            if (hit && o == 8) begin
                m_en[i] = d[0]; m_os[i] = d[1]; m_ie[i] = d[2];
            end else if (match && m_os[i]) begin
                m_en[i] = 0;
            end
        end
        if (w && c == 15 && o == 0) begin
            m_pre = d[7:0]; m_pcnt = 0;
        end else begin
            m_pcnt = tick ? 0 : m_pcnt + 1;
        end
    endfunction

    task automatic cycle(input bit rst_b, input bit do_rd, input bit do_wr,
                         input logic [11:0] a, input logic [31:0] d,
                         input bit use_const, input logic [31:0] cval);
        @(negedge clk);
        reset  = rst_b;
        CS_N   = !(do_rd | do_wr);
        RD_N   = !do_rd;
        WR_N   = !do_wr;
        Addr   = a;
        DataIn = d;
        if (do_rd) rd_q.push_back(use_const ? cval : model_read(a));
        irq_q.push_back(model_irq());
        model_step(rst_b, do_wr, a, d);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b0, 1'b1, a, d, 1'b0, 32'd0);
    endtask
    task automatic rd(input logic [11:0] a);
        cycle(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b0, 32'd0);
    endtask
    task automatic rdc(input logic [11:0] a, input logic [31:0] v);
        cycle(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b1, v);
    endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 32'd0);
    endtask

    // Monitor: compare the IRQ lines every cycle and DataOut on every read strobe
    always begin
        logic [3:0]  ei;
        logic [31:0] ed;
        @(negedge clk);
        #2;
        if (irq_q.size() > 0) begin
            ei = irq_q.pop_front();
            checks++;
            if (IrqVec !== ei) begin
                errors++;
                $display("FAIL irqvec t=%0t got=%b exp=%b", $time, IrqVec, ei);
            end
            checks++;
            if (Intr !== ~|ei) begin
                errors++;
                $display("FAIL intr t=%0t got=%b exp=%b", $time, Intr, ~|ei);
            end
        end
        if (!CS_N && !RD_N) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected t=%0t addr=%h got=%h exp=none", $time, Addr, DataOut);
            end else begin
                ed = rd_q.pop_front();
                if (DataOut !== ed) begin
                    errors++;
                    $display("FAIL read addr=%h t=%0t got=%h exp=%h", Addr, $time, DataOut, ed);
                end
            end
        end
    end

    initial begin
        bit found;
        reset = 1'b0; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1; Addr = 12'h000; DataIn = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset values and CTRL readback
        rdc(12'h000, 32'hFFFF_FFFF);
        rdc(12'h008, 32'd0);
        rdc(12'hF00, 32'd0);
        wr(12'h008, 32'd7);
        rdc(12'h008, 32'd7);
        wr(12'h008, 32'd0);

        // Periodic ch0, every 5 ticks
        wr(12'hF00, 32'd0);
        wr(12'h000, 32'd4);
        wr(12'h008, 32'd5);
        idle(4);
        rdc(12'h00C, 32'd0);
        rdc(12'h00C, 32'd1);
        wr(12'h00C, 32'd1);
        idle(12);

        // W1C on the exact cycle of a match: set must win
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_en[0] && m_pcnt == m_pre && m_cnt[0] == m_cmp[0]) begin
                wr(12'h00C, 32'd1);
                found = 1'b1;
            end else begin
                idle(1);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL contention_window got=0 exp=1");
        end
        rdc(12'h00C, 32'd1);
        idle(2);
        wr(12'h000, 32'd4);
        rdc(12'h004, 32'd0);

        // Prescaler with ch1
        wr(12'hF00, 32'd3);
        wr(12'h100, 32'd2);
        wr(12'h108, 32'd5);
        for (int k = 0; k < 8; k++) begin
            idle(1);
            rd(12'h104);
        end
        idle(4);

        // One-shot ch2 without IE
        wr(12'h200, 32'd3);
        wr(12'h208, 32'd3);
        idle(30);
        rdc(12'h208, 32'd2);
        rdc(12'h20C, 32'd1);
        rdc(12'h204, 32'd0);

        // Simultaneous match on ch0 and ch3
        wr(12'h008, 32'd0);
        wr(12'h108, 32'd0);
        wr(12'h00C, 32'd1);
        wr(12'h10C, 32'd1);
        wr(12'hF00, 32'd200);
        wr(12'h000, 32'd2);
        wr(12'h300, 32'd2);
        wr(12'h008, 32'd5);
        wr(12'h308, 32'd5);
        wr(12'hF00, 32'd0);
        idle(3);
        rdc(12'hF04, 32'd9);

        // Out-of-range channel and unmapped offset
        wr(12'h500, 32'h1234);
        rdc(12'h500, 32'd0);
        rdc(12'h508, 32'd0);
        rdc(12'h010, 32'd0);
        rdc(12'h000, 32'd2);

        // Reset mid-count with a concurrent write
        cycle(1'b0, 1'b0, 1'b1, 12'h000, 32'd5, 1'b0, 32'd0);
        rdc(12'h000, 32'hFFFF_FFFF);
        rdc(12'h004, 32'd0);
        rdc(12'h008, 32'd0);
        rdc(12'h00C, 32'd0);
        rdc(12'hF00, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r = $urandom_range(0, 99);
            int chs = $urandom_range(0, 7);
            logic [3:0]  c = (chs < 6) ? 4'(chs) : 4'hF;
            logic [7:0]  o = 8'($urandom_range(0, 4) * 4);
            logic [31:0] d;
            if (c == 4'hF)         d = $urandom_range(0, 3);
            else if (o == 8'h00)   d = $urandom_range(0, 10);
            else if (o == 8'h08)   d = $urandom_range(0, 7);
            else                   d = $urandom;
            if (r < 1)       cycle(1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 32'd0);
            else if (r < 45) idle(1);
            else if (r < 75) rd({c, o});
            else             wr({c, o}, d);
        end

        idle(2);
        @(negedge clk);
        #5;
        checks++;
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d/%0d exp=0/0", rd_q.size(), irq_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
